sipo_word_receiver: RTL and testbench
=====================================

// Module: sipo_word_receiver
// PURPOSE
//  Serial-in/parallel-out receiver that sits directly downstream of the 4-bit PISO shift stage.
//  - Collects the MSB-first bit stream into N-bit words, qualified by a per-bit strobe.
//  - Frames each word with a start pulse.
//  - Presents completed words through a one-entry valid/ready output buffer with sticky overrun detection.
// PARAMETERS
//  N     4  data bits per word (>=2)
//  CONT  0  1: stay in SHIFT after a word (back-to-back words); 0: return to IDLE, await frame_start
// PORTS
//  clk          in   1  single clock; all state updates on posedge
//  clear_n      in   1  asynchronous active-low reset
//  sin          in   1  serial data bit (the PISO out)
//  sin_en       in   1  bit strobe: sin is sampled only in cycles where sin_en=1
//  frame_start  in   1  1-cycle pulse marking the first bit of a word; may coincide with sin_en
//  pout         out  N  received word, MSB = first bit received
//  pout_valid   out  1  pout holds an unconsumed word
//  pout_ready   in   1  consumer accepts pout when pout_valid & pout_ready at posedge
//  overrun      out  1  sticky: a completed word was dropped because the buffer was full
//  clr_ovr      in   1  synchronous clear of overrun
//  busy         out  1  1 while in SHIFT
//  parity_err   out  1  parity result for the word in pout (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (clear_n=0, async): state=IDLE, shift reg=0, bit_cnt=0, pout=0, pout_valid=0, overrun=0, parity_err=0, busy=0.
//  - FSM IDLE -> SHIFT on frame_start=1. If sin_en=1 in that same cycle, that sin is bit 1 of the word.
//  - SHIFT: on each sin_en=1, sreg <= {sreg[N-2:0],sin}; bit_cnt++. Cycles with sin_en=0 hold all state.
//  - Word completes on the strobe that brings bit_cnt to W (W=N, or N+1 with parity).
//    That cycle bit_cnt -> 0 and the word, including the final bit, is offered to the buffer.
//    Next state: SHIFT if CONT=1, else IDLE.
//  - frame_start while in SHIFT: partial word discarded; bit_cnt restarts.
//    A coincident sin_en bit becomes bit 1 of the new word.
//    frame_start on the word-completing strobe: the completed word is delivered first, then the restart applies.
//  - Buffer load: word copied into pout with pout_valid=1 on the completion edge if pout_valid=0, or if pout_valid & pout_ready in that same cycle (simultaneous drain+load; pout_valid stays 1).
//  - Buffer full: otherwise the new word is dropped, pout is unchanged and overrun <= 1.
//  - Drain: pout_valid & pout_ready with no load -> pout_valid <= 0; pout keeps its last value.
//  - Latency: pout_valid rises 1 clk after the completing strobe edge; one word per W strobes maximum.
//  - overrun is cleared only by clr_ovr=1 or reset. If clr_ovr and a new overrun occur in the same cycle, the set wins.
//  - busy = (state==SHIFT), registered with state.
//  - bit_cnt width $clog2(W+1); never exceeds W-1 between words.
//  - Reset mid-word or mid-handshake: everything returns to reset values immediately; the pending word is lost.
// CONFIGURATION
//  SIPO_PARITY_EN defined:
//   - W=N+1; the bit after the N data bits is an even-parity bit and is not shifted into pout.
//   - parity_err loads together with pout: 1 if ^{data,parity_bit}==1, else 0.
//   - A word with bad parity is still delivered.
//  SIPO_PARITY_EN undefined: W=N; parity_err is tied to 0.
// TESTING (N=4, CONT=0 unless stated)
//  1. Reset release; frame_start+sin_en with bits 1,0,1,1 on 4 consecutive clks -> pout=4'b1011, pout_valid=1 one clk after the 4th strobe.
//  2. Same stream, sin_en toggling 1,0,1,0,... -> identical pout=4'b1011; busy=1 throughout the 7-clk span.
//  3. pout_ready=0, two frames 1011 then 0110 -> pout stays 1011, overrun=1. clr_ovr pulse -> overrun=0.
//     CONT=1 with pout_ready=1 on the completion cycle -> back-to-back words 1011 then 0110, pout_valid held 1.
//  4. frame_start reasserted after 2 bits (1,0), then bits 0,1,1,0 -> pout=4'b0110; first partial word discarded, no overrun.
//  5. clear_n pulsed low after 3 bits of a frame -> all outputs 0 immediately. A subsequent full frame 1001 -> pout=4'b1001.
//  6. SIPO_PARITY_EN: bits 1,0,1,1 + parity 1 -> pout=1011, parity_err=0. Parity bit 0 instead -> parity_err=1, word still delivered.

Source files
------------

// File: rtl/sipo_word_receiver.sv
// sipo_word_receiver
//   Serial-in/parallel-out receiver for an MSB-first bit stream. Bits are
//   taken only on cycles with sin_en=1. A frame_start pulse marks the first
//   bit of a word. Each completed word goes into a one-entry valid/ready
//   output buffer. If the buffer is full, the word is dropped and a sticky
//   overrun flag is set.
//
//   Optional feature macro: SIPO_PARITY_EN
//     defined   : each word carries one extra even-parity bit after the N data
//                 bits. parity_err is loaded together with pout.
//     undefined : words are N bits and parity_err is tied to 0.
//
//   The FSM state is visible on the busy output (1 = SHIFT).
//
//   Handshake: pout is consumed at a posedge where pout_valid & pout_ready.
//   pout_valid never drops without such a consume, except on reset.
//
// Ports
//   clk          clock, all state updates on posedge
//   clear_n      asynchronous active-low reset
//   sin          serial data bit
//   sin_en       bit strobe qualifying sin
//   frame_start  one-cycle pulse marking the first bit of a word
//   pout         received word, MSB = first bit received
//   pout_valid   pout holds an unconsumed word
//   pout_ready   consumer accepts pout
//   overrun      sticky: a completed word was dropped (buffer full)
//   clr_ovr      synchronous clear of overrun (a new overrun wins)
//   busy         1 while the FSM is in SHIFT
//   parity_err   parity result for the word in pout
module sipo_word_receiver #(
    parameter int N    = 4,
    parameter bit CONT = 1'b0
) (
    input  logic         clk,
    input  logic         clear_n,
    input  logic         sin,
    input  logic         sin_en,
    input  logic         frame_start,
    output logic [N-1:0] pout,
    output logic         pout_valid,
    input  logic         pout_ready,
    output logic         overrun,
    input  logic         clr_ovr,
    output logic         busy,
    output logic         parity_err
);

`ifdef SIPO_PARITY_EN
    localparam int W = N + 1;
`else
    localparam int W = N;
`endif
    localparam int CW = $clog2(W + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t         state, state_nx;
    // Only the first W-1 bits are stored. The final bit is taken straight
    // from sin on the completing strobe.
    logic [W-2:0]   sreg, sreg_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic [W-1:0]   word;
    logic           offer;
    logic [N-1:0]   data;
    logic           load;
    logic           drop;

    always_comb begin
        state_nx = state;
        sreg_nx  = sreg;
        cnt_nx   = cnt;
        offer    = 1'b0;
        word     = {sreg, sin};
        case (state)
            IDLE: begin
                if (frame_start) begin
                    state_nx = SHIFT;
                    sreg_nx  = '0;
                    cnt_nx   = '0;
                    if (sin_en) begin
                        sreg_nx = {{(W-2){1'b0}}, sin};
                        cnt_nx  = CW'(1);
                    end
                end
            end
            SHIFT: begin
                if (sin_en && cnt == CW'(W - 1)) begin
                    // The completing strobe wins over a coincident frame_start.
                    // The word is delivered, then the counter restarts empty.
                    offer    = 1'b1;
                    cnt_nx   = '0;
                    sreg_nx  = '0;
                    state_nx = (CONT || frame_start) ? SHIFT : IDLE;
                end else if (frame_start) begin
                    // Discard the partial word. A coincident bit becomes bit 1.
                    sreg_nx = '0;
                    cnt_nx  = '0;
                    if (sin_en) begin
                        sreg_nx = {{(W-2){1'b0}}, sin};
                        cnt_nx  = CW'(1);
                    end
                end else if (sin_en) begin
                    sreg_nx = word[W-2:0];
                    cnt_nx  = cnt + CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef SIPO_PARITY_EN
    assign data = word[W-1:1];
`else
    assign data = word;
`endif

    // A word is accepted if the buffer is empty, or if it is being drained
    // on this same edge.
    assign load = offer && (!pout_valid || pout_ready);
    assign drop = offer && pout_valid && !pout_ready;
    assign busy = (state == SHIFT);

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state      <= IDLE;
            sreg       <= '0;
            cnt        <= '0;
            pout       <= '0;
            pout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state <= state_nx;
            sreg  <= sreg_nx;
            cnt   <= cnt_nx;
            if (load) begin
                pout       <= data;
                pout_valid <= 1'b1;
            end else if (pout_valid && pout_ready) begin
                pout_valid <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef SIPO_PARITY_EN
    // Even parity over the data bits plus the parity bit. A result of 1
    // means an error. The word is delivered either way.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            parity_err <= 1'b0;
        end else if (load) begin
            parity_err <= ^word;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_word_receiver.sv
// Testbench for sipo_word_receiver.
// It drives two instances (CONT=0 and CONT=1) from the same input stream.
// The checker is a frame-level reference model with one expected-word queue
// per instance. A word is pushed when the model completes it and pops when
// the consumer takes it. Directed scenarios run first, then random stimulus.
module tb_sipo_word_receiver;
  localparam int N = 4;
`ifdef SIPO_PARITY_EN
  localparam int W = N + 1;
`else
  localparam int W = N;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic clear_n = 1'b0;
  always #5 clk = ~clk;

  logic sin = 1'b0, sin_en = 1'b0, frame_start = 1'b0;
  logic pout_ready = 1'b0, clr_ovr = 1'b0;
  logic [N-1:0] pout0, pout1;
  logic v0, v1, o0, o1, b0, b1, pe0, pe1;

  sipo_word_receiver #(.N(N), .CONT(1'b0)) dut0 (
    .clk(clk), .clear_n(clear_n), .sin(sin), .sin_en(sin_en),
    .frame_start(frame_start), .pout(pout0), .pout_valid(v0),
    .pout_ready(pout_ready), .overrun(o0), .clr_ovr(clr_ovr),
    .busy(b0), .parity_err(pe0)
  );

  sipo_word_receiver #(.N(N), .CONT(1'b1)) dut1 (
    .clk(clk), .clear_n(clear_n), .sin(sin), .sin_en(sin_en),
    .frame_start(frame_start), .pout(pout1), .pout_valid(v1),
    .pout_ready(pout_ready), .overrun(o1), .clr_ovr(clr_ovr),
    .busy(b1), .parity_err(pe1)
  );

  int n_cmp = 0;
  int n_err = 0;

  // scoreboard: expected {parity_err, pout}, one queue per instance
  logic [N:0] exp_q0[$];
  logic [N:0] exp_q1[$];

  // reference model state
  logic       m_in[2];
  int         m_cnt[2];
  logic [W-1:0] m_val[2];
  logic       m_ovr[2];
  logic [N:0] m_last[2];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic [N:0] mk_word(input logic [W-1:0] v);
`ifdef SIPO_PARITY_EN
    return {^v, v[W-1:1]};
`else
    return {1'b0, v};
`endif
  endfunction

  function automatic logic [W-1:0] frame_of(input logic [N-1:0] d, input logic bad);
`ifdef SIPO_PARITY_EN
    return {d, (^d) ^ bad};
`else
    return bad ? d : d;
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_in[k] = 1'b0;
      m_cnt[k] = 0;
      m_val[k] = '0;
      m_ovr[k] = 1'b0;
      m_last[k] = '0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // One clock of the model for instance k.
  // A word is a run of W strobed bits inside a frame.
  task automatic step(input int k);
    logic done;
    logic drop;
    logic [N:0] w;
    done = 1'b0;
    drop = 1'b0;
    if (m_in[k] && sin_en) begin
      m_val[k] = (m_val[k] << 1) | W'(sin);
      m_cnt[k]++;
      if (m_cnt[k] == W) begin
        w = mk_word(m_val[k]);
        done = 1'b1;
        m_cnt[k] = 0;
        m_val[k] = '0;
        m_in[k] = (k == 1);
        if (k == 0) begin
          if (exp_q0.size() == 0) exp_q0.push_back(w); else drop = 1'b1;
        end else begin
          if (exp_q1.size() == 0) exp_q1.push_back(w); else drop = 1'b1;
        end
      end
    end
    if (frame_start) begin
      m_in[k] = 1'b1;
      if (!done) begin
        m_cnt[k] = sin_en ? 1 : 0;
        m_val[k] = W'(sin_en & sin);
      end
    end
    if (drop) m_ovr[k] = 1'b1;
    else if (clr_ovr) m_ovr[k] = 1'b0;
  endtask

  always @(posedge clk or negedge clear_n) begin
    if (!clear_n) model_reset();
    else begin
      step(0);
      step(1);
    end
  end

  // monitor: compare on the falling edge
  task automatic mon(input int k, input logic v, input logic [N:0] pw, input logic o, input logic b);
    int sz;
    logic [N:0] front;
    sz = (k == 0) ? exp_q0.size() : exp_q1.size();
    check($sformatf("dut%0d pout_valid", k), v, sz != 0);
    if (sz != 0) begin
      front = (k == 0) ? exp_q0[0] : exp_q1[0];
      check($sformatf("dut%0d word", k), pw, front);
      if (pout_ready) begin
        if (k == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
        m_last[k] = front;
      end
    end else begin
      check($sformatf("dut%0d hold", k), pw, m_last[k]);
    end
    check($sformatf("dut%0d overrun", k), o, m_ovr[k]);
    check($sformatf("dut%0d busy", k), b, m_in[k]);
  endtask

  always @(negedge clk) begin
    mon(0, v0, {pe0, pout0}, o0, b0);
    mon(1, v1, {pe1, pout1}, o1, b1);
  end

  // driver tasks
  task automatic cyc(input logic fs, input logic en, input logic b);
    frame_start = fs;
    sin_en = en;
    sin = b;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    sin_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input logic [W-1:0] v, input bit gaps);
    for (int i = W - 1; i >= 0; i--) begin
      cyc(i == W - 1, 1'b1, v[i]);
      if (gaps && i > 0) cyc(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic chk_reset_outputs();
    check("rst pout0", pout0, 0);
    check("rst valid0", v0, 0);
    check("rst ovr0", o0, 0);
    check("rst busy0", b0, 0);
    check("rst perr0", pe0, 0);
    check("rst pout1", pout1, 0);
    check("rst valid1", v1, 0);
    check("rst ovr1", o1, 0);
    check("rst busy1", b1, 0);
    check("rst perr1", pe1, 0);
  endtask

  initial begin
    logic [W-1:0] f;
    model_reset();
    clear_n = 1'b0;
    pout_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    clear_n = 1'b1;

    // 1: plain frame 1011
    send_frame(frame_of(4'b1011, 1'b0), 1'b0);
    idle(3);
    // 2: same stream with strobe gaps
    send_frame(frame_of(4'b1011, 1'b0), 1'b1);
    idle(3);
    // 3: consumer stalled, second word dropped, then clear overrun
    pout_ready = 1'b0;
    send_frame(frame_of(4'b1011, 1'b0), 1'b0);
    idle(1);
    send_frame(frame_of(4'b0110, 1'b0), 1'b0);
    idle(2);
    check("stall ovr0", o0, 1);
    check("stall pout0", pout0, 4'b1011);
    pout_ready = 1'b1;
    idle(2);
    clr_ovr = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    clr_ovr = 1'b0;
    idle(2);
    check("clr ovr0", o0, 0);
    // 3b: back-to-back words with no second frame_start (CONT=1 only)
    send_frame(frame_of(4'b1011, 1'b0), 1'b0);
    f = frame_of(4'b0110, 1'b0);
    for (int i = W - 1; i >= 0; i--) cyc(1'b0, 1'b1, f[i]);
    idle(3);
    // 4: restart after two bits
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    send_frame(frame_of(4'b0110, 1'b0), 1'b0);
    idle(3);
    check("restart ovr0", o0, 0);
    // 6: parity good and bad (no parity bit in the default build)
    send_frame(frame_of(4'b1011, 1'b0), 1'b0);
    idle(2);
    send_frame(frame_of(4'b1011, 1'b1), 1'b0);
    idle(2);
    // 5: reset after three bits of a frame
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    clear_n = 1'b0;
    #1;
    chk_reset_outputs();
    @(posedge clk);
    #1;
    clear_n = 1'b1;
    send_frame(frame_of(4'b1001, 1'b0), 1'b0);
    idle(3);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      pout_ready = ($urandom_range(0, 3) != 0);
      clr_ovr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 599) == 0) begin
        clear_n = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        clear_n = 1'b1;
      end else begin
        cyc($urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)));
      end
    end
    clr_ovr = 1'b0;
    pout_ready = 1'b1;
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
